// File: rtl/bus_router.sv
// bus_router: one master to N_SLAVES slaves on the Vermicel valid/ready bus.
// A slave index is decoded from address bits [SEL_LSB +: SEL_BITS]. The request
// is registered and forwarded to exactly one slave, and that slave's read data
// is returned one cycle after it is ready. Unmapped accesses are answered with
// ERR_DATA and an m_err pulse. Slave IRQs are merged into one registered line.
// Optional feature macro: BUS_ROUTER_TIMEOUT_EN. When it is defined, a slave
// that stalls for TIMEOUT cycles is abandoned and an error response is returned.
module bus_router #(
   parameter int N_SLAVES = 4,
   parameter int WIDTH    = 32,
   parameter int SEL_LSB  = 28,
   parameter int TIMEOUT  = 255,
   parameter logic [WIDTH-1:0] ERR_DATA = WIDTH'(32'hDEAD_BEEF)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      m_valid,
   input  logic [WIDTH-1:0]          m_address,
   input  logic [WIDTH/8-1:0]        m_wstrobe,
   input  logic [WIDTH-1:0]          m_wdata,
   output logic                      m_ready,
   output logic [WIDTH-1:0]          m_rdata,
   output logic                      m_irq,
   output logic                      m_err,
   output logic [N_SLAVES-1:0]       s_valid,
   output logic [WIDTH-1:0]          s_address,
   output logic [WIDTH/8-1:0]        s_wstrobe,
   output logic [WIDTH-1:0]          s_wdata,
   input  logic [N_SLAVES-1:0]       s_ready,
   input  logic [N_SLAVES*WIDTH-1:0] s_rdata,
   input  logic [N_SLAVES-1:0]       s_irq
);

   localparam int SEL_BITS = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    addr_q, addr_d;
   logic [WIDTH-1:0]    wdata_q, wdata_d;
   logic [WIDTH/8-1:0]  wstrb_q, wstrb_d;
   logic [WIDTH-1:0]    rdata_q, rdata_d;
   logic [SEL_BITS-1:0] idx_q, idx_d;
   logic                err_q, err_d;
   logic                irq_q;

   logic [SEL_BITS-1:0] req_sel;
   logic                req_mapped;
   logic                sel_ready;
   logic [WIDTH-1:0]    sel_rdata;
   logic                timeout_hit;

   // Index field of the incoming address; the extra zero bit keeps the compare
   // correct when N_SLAVES fills the whole field.
   assign req_sel    = m_address[SEL_LSB +: SEL_BITS];
   assign req_mapped = {1'b0, req_sel} < (SEL_BITS+1)'(N_SLAVES);

   // One-hot slave request, decoded from the latched index while in ACCESS.
   generate
      for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_sel
         assign s_valid[gi] = (state_q == ACCESS) && (idx_q == SEL_BITS'(gi));
      end
   endgenerate

   // Only the selected slave's ready counts; all other ready bits are masked.
   assign sel_ready = |(s_ready & s_valid);

   // Read-data mux driven by the latched index.
   always_comb begin
      sel_rdata = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (idx_q == SEL_BITS'(k)) sel_rdata = s_rdata[k*WIDTH +: WIDTH];
      end
   end

`ifdef BUS_ROUTER_TIMEOUT_EN
   logic [15:0] cnt_q, cnt_d;
   assign timeout_hit = (cnt_q == 16'(TIMEOUT));

   // Stall counter; cleared when ACCESS is entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state and datapath logic for the IDLE/ACCESS/RESPOND sequence.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      rdata_d = rdata_q;
      idx_d   = idx_q;
      err_d   = err_q;
`ifdef BUS_ROUTER_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (m_valid) begin
               addr_d  = m_address;
               wdata_d = m_wdata;
               wstrb_d = m_wstrobe;
               if (req_mapped) begin
                  idx_d   = req_sel;
                  err_d   = 1'b0;
                  state_d = ACCESS;
`ifdef BUS_ROUTER_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  rdata_d = ERR_DATA;
                  err_d   = 1'b1;
                  state_d = RESPOND;
               end
            end
         end
         ACCESS: begin
            // A ready arriving on the timeout cycle takes priority.
            if (sel_ready) begin
               rdata_d = sel_rdata;
               err_d   = 1'b0;
               state_d = RESPOND;
            end else if (timeout_hit) begin
               rdata_d = ERR_DATA;
               err_d   = 1'b1;
               state_d = RESPOND;
            end else begin
`ifdef BUS_ROUTER_TIMEOUT_EN
               cnt_d   = cnt_q + 16'd1;
`endif
            end
         end
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and payload registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         rdata_q <= rdata_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
      end
   end

   // Interrupt merge; it runs independently of the FSM, with one cycle of latency.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) irq_q <= 1'b0;
      else        irq_q <= |s_irq;
   end

   assign m_ready   = (state_q == RESPOND);
   assign m_err     = (state_q == RESPOND) && err_q;
   assign m_rdata   = rdata_q;
   assign m_irq     = irq_q;
   assign s_address = addr_q;
   assign s_wstrobe = wstrb_q;
   assign s_wdata   = wdata_q;

endmodule

// File: tb/tb_bus_router.sv
// Testbench for bus_router. It drives a 4-slave instance (A) and a 3-slave
// instance (B) from one master driver. A scoreboard queue holds the expected
// responses, and the monitor pops and compares one entry per m_ready pulse.
// Timeout cases run only when BUS_ROUTER_TIMEOUT_EN is defined.
module tb_bus_router;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_valid;
   logic        use_b;
   logic [31:0] m_address;
   logic [31:0] m_wdata;
   logic [3:0]  m_wstrobe;
   logic [3:0]  s_irq;

   // Instance A: 4 slaves with a configurable wait-state model.
   logic        a_valid, a_m_ready, a_m_irq, a_m_err;
   logic [31:0] a_m_rdata, a_s_address, a_s_wdata;
   logic [3:0]  a_s_wstrobe, a_s_valid, a_s_ready;
   logic [127:0] a_s_rdata;

   // Instance B: 3 slaves, all zero-wait, used for the unmapped index.
   logic        b_valid, b_m_ready, b_m_irq, b_m_err;
   logic [31:0] b_m_rdata, b_s_address, b_s_wdata;
   logic [3:0]  b_s_wstrobe;
   logic [2:0]  b_s_valid, b_s_ready, b_s_irq;
   logic [95:0] b_s_rdata;

   logic [31:0] slave_data [4];
   int          wait_cfg [4];
   logic [3:0]  noise_rdy;
   int          acc_cnt = 0;
   int          cyc_cnt = 0;

   int n_checks = 0;
   int n_errors = 0;
   int n_txn    = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          start;
   } exp_t;
   exp_t sb_q [$];

   assign a_valid = m_valid & ~use_b;
   assign b_valid = m_valid & use_b;
   assign b_s_ready = b_s_valid;
   assign b_s_irq   = 3'b000;
   assign b_s_rdata = {32'hBBBB_0002, 32'hBBBB_0001, 32'hBBBB_0000};

   bus_router #(.N_SLAVES(4), .WIDTH(32), .SEL_LSB(28), .TIMEOUT(8),
                .ERR_DATA(32'hDEAD_BEEF)) dut_a (
      .clk(clk), .reset(reset), .m_valid(a_valid), .m_address(m_address),
      .m_wstrobe(m_wstrobe), .m_wdata(m_wdata), .m_ready(a_m_ready),
      .m_rdata(a_m_rdata), .m_irq(a_m_irq), .m_err(a_m_err),
      .s_valid(a_s_valid), .s_address(a_s_address), .s_wstrobe(a_s_wstrobe),
      .s_wdata(a_s_wdata), .s_ready(a_s_ready), .s_rdata(a_s_rdata),
      .s_irq(s_irq)
   );

   bus_router #(.N_SLAVES(3), .WIDTH(32), .SEL_LSB(28), .TIMEOUT(8),
                .ERR_DATA(32'hDEAD_BEEF)) dut_b (
      .clk(clk), .reset(reset), .m_valid(b_valid), .m_address(m_address),
      .m_wstrobe(m_wstrobe), .m_wdata(m_wdata), .m_ready(b_m_ready),
      .m_rdata(b_m_rdata), .m_irq(b_m_irq), .m_err(b_m_err),
      .s_valid(b_s_valid), .s_address(b_s_address), .s_wstrobe(b_s_wstrobe),
      .s_wdata(b_s_wdata), .s_ready(b_s_ready), .s_rdata(b_s_rdata),
      .s_irq(b_s_irq)
   );

   // Slave model: ready after wait_cfg[k] cycles of s_valid. A set noise_rdy
   // bit holds that slave's ready high regardless of its s_valid.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_slave
         assign a_s_rdata[gi*32 +: 32] = slave_data[gi];
         assign a_s_ready[gi] = (a_s_valid[gi] && (acc_cnt == wait_cfg[gi])) || noise_rdy[gi];
      end
   endgenerate

   always @(posedge clk) acc_cnt <= (|(a_s_valid & ~a_s_ready)) ? acc_cnt + 1 : 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
   always #5 clk = ~clk;

   // Observation mux for whichever instance is currently addressed.
   logic        m_ready_x, m_err_x;
   logic [31:0] m_rdata_x, s_addr_x, s_wdata_x;
   logic [3:0]  s_valid_x, s_wstrb_x;
   assign m_ready_x = use_b ? b_m_ready   : a_m_ready;
   assign m_err_x   = use_b ? b_m_err     : a_m_err;
   assign m_rdata_x = use_b ? b_m_rdata   : a_m_rdata;
   assign s_addr_x  = use_b ? b_s_address : a_s_address;
   assign s_wdata_x = use_b ? b_s_wdata   : a_s_wdata;
   assign s_wstrb_x = use_b ? b_s_wstrobe : a_s_wstrobe;
   assign s_valid_x = use_b ? {1'b0, b_s_valid} : a_s_valid;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Response monitor: one scoreboard entry per m_ready pulse.
   always @(negedge clk) begin
      if (reset === 1'b1 && m_ready_x === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            n_txn++;
            $display("txn %0d: dut=%s rdata=%h err=%0d latency=%0d",
                     n_txn, use_b ? "B" : "A", m_rdata_x, m_err_x, cyc_cnt - e.start);
            check("rdata", m_rdata_x, e.rdata);
            check("err", 32'(m_err_x), 32'(e.err));
            check("latency", 32'(cyc_cnt - e.start), 32'(e.lat));
         end
      end
   end

   // Issue one request; must be called at a negedge. lead = idle cycles before
   // ACCESS begins (1 when chained directly behind a previous response).
   // exp_idx < 0 marks an unmapped access.
   task automatic issue(input logic b, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_idx, input int lead);
      exp_t e;
      logic [3:0] oh;
      bit done;
      oh = (exp_idx < 0) ? 4'b0000 : 4'(1 << exp_idx);
      use_b = b;
      m_address = addr;
      m_wstrobe = strb;
      m_wdata = wd;
      m_valid = 1'b1;
      e.rdata = exp_rd;
      e.err = exp_err;
      e.lat = exp_lat + lead;
      e.start = cyc_cnt;
      sb_q.push_back(e);
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (m_ready_x) begin
            done = 1'b1;
            m_valid = 1'b0;
            check("s_valid_resp", 32'(s_valid_x), 32'd0);
         end else if (i < lead) begin
            check("s_valid_idle", 32'(s_valid_x), 32'd0);
         end else begin
            check("s_valid", 32'(s_valid_x), 32'(oh));
            if (exp_idx >= 0) begin
               check("s_address", s_addr_x, addr);
               check("s_wstrobe", 32'(s_wstrb_x), 32'(strb));
               check("s_wdata", s_wdata_x, wd);
            end
         end
      end
      if (!done) begin
         check("resp_timeout", 32'd0, 32'd1);
         m_valid = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      m_valid = 1'b0;
      use_b = 1'b0;
      m_address = '0;
      m_wdata = '0;
      m_wstrobe = '0;
      s_irq = '0;
      noise_rdy = '0;
      for (int k = 0; k < 4; k++) begin
         slave_data[k] = 32'h5000_0000 + 32'(k);
         wait_cfg[k] = 0;
      end

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_m_ready", 32'(a_m_ready), 32'd0);
      check("rst_m_rdata", a_m_rdata, 32'd0);
      check("rst_s_valid", 32'(a_s_valid), 32'd0);
      check("rst_s_address", a_s_address, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Mapped read, zero wait, slave 1 ready tied high.
      slave_data[1] = 32'h1234_5678;
      noise_rdy = 4'b0010;
      issue(1'b0, 32'h1000_0004, 4'b0000, 32'h0, 32'h1234_5678, 1'b0, 2, 1, 0);
      noise_rdy = 4'b0000;
      @(negedge clk);

      // Write with 5 wait states on slave 3; other slaves' ready held high.
      slave_data[3] = 32'h3333_0003;
      wait_cfg[3] = 5;
      noise_rdy = 4'b0111;
      issue(1'b0, 32'h3000_0000, 4'b0011, 32'hCAFE_0001, 32'h3333_0003, 1'b0, 7, 3, 0);
      noise_rdy = 4'b0000;
      wait_cfg[3] = 0;
      @(negedge clk);

      // Unmapped access on the 3-slave instance, then a mapped one.
      issue(1'b1, 32'h3000_0000, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 1, -1, 0);
      @(negedge clk);
      issue(1'b1, 32'h2000_0008, 4'b1111, 32'h0000_0055, 32'hBBBB_0002, 1'b0, 2, 2, 0);
      @(negedge clk);
      use_b = 1'b0;

      // Back-to-back requests with m_valid held across the response.
      slave_data[2] = 32'hAAAA_0002;
      wait_cfg[2] = 1;
      slave_data[0] = 32'h0000_5A5A;
      issue(1'b0, 32'h2000_0000, 4'b0000, 32'h0, 32'hAAAA_0002, 1'b0, 3, 2, 0);
      issue(1'b0, 32'h0000_0100, 4'b1111, 32'h0000_0077, 32'h0000_5A5A, 1'b0, 2, 0, 1);
      wait_cfg[2] = 0;
      @(negedge clk);

`ifdef BUS_ROUTER_TIMEOUT_EN
      // Timeout: slave 0 never ready, then ready exactly when the counter hits 8.
      wait_cfg[0] = 1000;
      issue(1'b0, 32'h0000_0010, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b1, 10, 0, 0);
      @(negedge clk);
      wait_cfg[0] = 8;
      issue(1'b0, 32'h0000_0014, 4'b0000, 32'h0, 32'h0000_5A5A, 1'b0, 10, 0, 0);
      @(negedge clk);
`endif

      // Reset in the middle of an ACCESS with a stalled slave.
      wait_cfg[0] = 1000;
      s_irq = 4'b0001;
      use_b = 1'b0;
      m_address = 32'h0000_0040;
      m_wstrobe = 4'b1111;
      m_wdata = 32'h0000_1111;
      m_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("pre_rst_s_valid", 32'(a_s_valid), 32'd1);
      check("pre_rst_m_irq", 32'(a_m_irq), 32'd1);
      #2;
      reset = 1'b0;
      s_irq = 4'b0000;
      #1;
      check("arst_s_valid", 32'(a_s_valid), 32'd0);
      check("arst_m_ready", 32'(a_m_ready), 32'd0);
      check("arst_m_err", 32'(a_m_err), 32'd0);
      check("arst_m_irq", 32'(a_m_irq), 32'd0);
      check("arst_m_rdata", a_m_rdata, 32'd0);
      check("arst_s_address", a_s_address, 32'd0);
      check("arst_s_wstrobe", 32'(a_s_wstrobe), 32'd0);
      check("arst_s_wdata", a_s_wdata, 32'd0);
      m_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("no_replay_m_ready", 32'(a_m_ready), 32'd0);
         check("no_replay_s_valid", 32'(a_s_valid), 32'd0);
      end
      wait_cfg[0] = 0;
      issue(1'b0, 32'h0000_0000, 4'b0000, 32'h0, 32'h0000_5A5A, 1'b0, 2, 0, 0);
      @(negedge clk);

      // One-cycle IRQ pulse on slave 2.
      check("irq_before", 32'(a_m_irq), 32'd0);
      s_irq = 4'b0100;
      @(negedge clk);
      check("irq_high", 32'(a_m_irq), 32'd1);
      s_irq = 4'b0000;
      @(negedge clk);
      check("irq_low1", 32'(a_m_irq), 32'd0);
      @(negedge clk);
      check("irq_low2", 32'(a_m_irq), 32'd0);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bus_router.md
# bus_router

Parametrised one-master-to-N-slave bus router for the Vermicel valid/ready bus. Sits between the CPU data port and the memory/peripheral slaves: decodes a slave index from address bits, registers the request, forwards it to exactly one slave, returns that slave's read data, and produces an error response for unmapped or stalled accesses. Slave interrupt lines are merged into one registered master IRQ.

## Interface
- `N_SLAVES`, default 4: number of slave ports, 1..16.
- `WIDTH`, default 32: address/data width; a multiple of 8.
- `SEL_LSB`, default 28: lowest address bit of the slave-index field; the field is `SEL_BITS = max(1, $clog2(N_SLAVES))` wide.
- `TIMEOUT`, default 255: slave-stall limit in cycles, 1..65535; used only with the timeout feature.
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on an error response.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `m_valid` in 1: master request.
- `m_address` in WIDTH: master address.
- `m_wstrobe` in WIDTH/8: byte write enables; 0 means a read.
- `m_wdata` in WIDTH: write data.
- `m_ready` out 1: one-cycle response strobe.
- `m_rdata` out WIDTH: response data, valid while `m_ready` = 1.
- `m_irq` out 1: registered OR of all `s_irq`.
- `m_err` out 1: one-cycle pulse with an error response.
- `s_valid` out N_SLAVES: per-slave request, one-hot or zero.
- `s_address` out WIDTH: registered address, shared by all slaves.
- `s_wstrobe` out WIDTH/8: registered strobes, shared.
- `s_wdata` out WIDTH: registered write data, shared.
- `s_ready` in N_SLAVES: per-slave ready.
- `s_rdata` in N_SLAVES*WIDTH: slave k's data is in slice [k*WIDTH +: WIDTH].
- `s_irq` in N_SLAVES: per-slave interrupt.

## Operation
- The FSM has three states: IDLE, ACCESS, RESPOND.
- **IDLE**: on `m_valid` = 1, latch address, wstrobe and wdata, and compute `idx = m_address[SEL_LSB +: SEL_BITS]`.
  - If `idx < N_SLAVES`, latch `idx` and go to ACCESS.
  - Otherwise, load `ERR_DATA`, set the error flag and go to RESPOND.
- **ACCESS**: `s_valid[idx]` = 1, all other `s_valid` bits = 0.
  - When `s_ready[idx]` = 1, capture `s_rdata[idx]` (for writes too) and go to RESPOND.
  - Ready bits of non-selected slaves are ignored.
- **RESPOND**: `m_ready` = 1 for exactly one cycle. `m_rdata` is the captured data. `m_err` equals the error flag. Then go to IDLE.
- **Request rules**: the master holds `m_valid` and its payload until `m_ready`. A request still asserted in the cycle after RESPOND is treated as a new request.
- **Shared slave outputs**: `s_address`, `s_wstrobe` and `s_wdata` are stable from ACCESS entry until RESPOND exit.
- **`m_rdata` outside RESPOND**: holds its last value; it is 0 after reset.
- **`m_irq`**: a flop of `|s_irq`, so there is one cycle of latency. It is independent of the FSM.
- **Reset values**: `reset` = 0 at any time, including mid-ACCESS, forces IDLE immediately.
  - `s_valid`, `m_ready`, `m_err`, `m_irq`, `m_rdata`, `s_address`, `s_wstrobe`, `s_wdata`, the timeout counter and the error flag all become 0.
  - An aborted transaction is not replayed.

## Timing
- **Mapped access with a zero-wait slave** (request `m_valid` seen at edge 0):
  - `s_valid` is high in cycle 1.
  - `s_ready` is high in cycle 1.
  - `m_ready` is high in cycle 2.
  - Minimum latency is 2 cycles; the throughput limit is 1 transaction per 3 cycles.
- **Slave wait states**: a slave inserting W wait cycles gives latency 2+W.
- **Unmapped access**: `m_ready` and `m_err` are high in cycle 1 (latency 1).
- **Path from `s_ready` to `m_ready`**: never combinational; it always goes through RESPOND.

## Configuration
- Macro: `BUS_ROUTER_TIMEOUT_EN`.
- **Defined**:
  - A 16-bit counter clears on ACCESS entry and increments each ACCESS cycle while `s_ready[idx]` = 0.
  - When the counter reaches `TIMEOUT`, `s_valid` is dropped, the captured data becomes `ERR_DATA`, the error flag is set, and the FSM goes to RESPOND.
  - Timeout latency is `TIMEOUT`+2 cycles from the request.
  - If `s_ready` arrives in the same cycle the counter hits `TIMEOUT`, `s_ready` wins: the access completes normally with no error.
- **Undefined**: no counter exists, ACCESS waits indefinitely, and `m_err` pulses only for unmapped accesses. `TIMEOUT` is ignored.

## Test plan
- **Mapped read, zero wait**: N_SLAVES=4, SEL_LSB=28. Read 32'h1000_0004 while slave 1 returns 32'h1234_5678 with `s_ready` tied 1. Required: `s_valid` = 4'b0010 in cycle 1; `m_ready` in cycle 2 with `m_rdata` = 32'h1234_5678 and `m_err` = 0.
- **Write with wait states**: write 32'hCAFE_0001 with wstrobe 4'b0011 to 32'h3000_0000, and slave 3 waits 5 cycles. Required: `s_wdata`, `s_wstrobe` and `s_address` stable for 6 cycles; `m_ready` at cycle 7; no other `s_valid` bit ever set.
- **Unmapped access**: N_SLAVES=3, access 32'h3000_0000. Required: `m_ready` = `m_err` = 1 in cycle 1, `m_rdata` = 32'hDEAD_BEEF, and `s_valid` stays 0.
- **Timeout** (macro defined, TIMEOUT=8, slave 0 never ready): required `m_err` with `m_rdata` = ERR_DATA at cycle 10, and `s_valid` low from then on. Repeat with `s_ready` asserted exactly on the 8th wait cycle: required normal data and `m_err` = 0.
- **Back-to-back requests**: issue two requests with `m_valid` held continuously. Required: two distinct `m_ready` pulses, each completing only its own transaction.
- **Reset and IRQ**: pull `reset` low mid-ACCESS. Required: all outputs 0 asynchronously, and IDLE after release. Then pulse `s_irq[2]` for 1 cycle: required `m_irq` high for exactly one cycle, one cycle later.
